// File: rtl/uart_rx_ctrl.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// uart_rx_ctrl
//
// UART receive controller. It watches an asynchronous idle-high serial line
// and works with an external baud generator. The generator produces one-clock
// mid-bit strobes on clk_bps while bps_start is high. Each frame is one start
// bit, eight data bits sent LSB first, an optional even-parity bit and one stop
// bit. Each received byte is presented on rx_data. rx_valid stays high until
// the consumer acknowledges the byte.
//
// Optional feature macro: UART_RX_PARITY_EN
//   When this macro is defined, an even-parity bit follows the data bits and
//   the parity_err output is present. When it is undefined, there is no parity
//   state and no parity_err port.
//
// Parameters
//   SYNC_STAGES  number of flops in the rs232_rx synchronizer (2 or 3)
//
// Ports
//   clk         in   system clock (25 MHz)
//   rst_n       in   asynchronous active-low reset
//   rs232_rx    in   asynchronous serial line, idle high
//   clk_bps     in   one-clock mid-bit sample strobe from the baud generator
//   bps_start   out  high requests baud strobes; low holds the generator idle
//   rx_data     out  last received byte
//   rx_valid    out  byte available; held until rx_ack
//   rx_ack      in   consumer accepts rx_data
//   frame_err   out  stop bit was sampled low for the byte in rx_data
//   parity_err  out  (UART_RX_PARITY_EN only) parity mismatch for rx_data
//   overrun     out  one-clock pulse: a byte completed over an unread byte
//   busy        out  high whenever the receiver is not idle
// ----------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  input  logic       clk_bps,
  output logic       bps_start,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun,
  output logic       busy
);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_sync;
  logic                   rx_prev;
  logic                   fall;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
`ifdef UART_RX_PARITY_EN
  logic                   par_q;
`endif

  // The synchronizer resets to the idle level, so leaving reset never
  // looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rs232_rx};
      rx_prev <= rx_sync;
    end
  end

  assign rx_sync = sync_q[SYNC_STAGES-1];

  // rx_prev is tracked in every state. A line that is already low when the
  // FSM returns to IDLE, such as a low stop bit, therefore does not count as
  // a new start edge.
  assign fall = rx_prev & ~rx_sync;

  // Sample storage is pure data. Only strobes in the matching state write it.
  always_ff @(posedge clk) begin
    if (state == DATA && clk_bps) begin
      shreg[bit_cnt] <= rx_sync;
    end
`ifdef UART_RX_PARITY_EN
    if (state == PARITY && clk_bps) begin
      par_q <= rx_sync;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      bps_start  <= 1'b0;
      busy       <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      overrun <= 1'b0;
      // A completion in the STOP branch below takes priority over this clear.
      // When both happen in the same clock, the new byte stays valid.
      if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (fall) begin
            state     <= START;
            bps_start <= 1'b1;
            busy      <= 1'b1;
          end
        end

        START: begin
          if (clk_bps) begin
            if (rx_sync) begin
              // The line went back high before mid-bit, so this was a glitch.
              state     <= IDLE;
              bps_start <= 1'b0;
              busy      <= 1'b0;
            end else begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
        end

        DATA: begin
          if (clk_bps) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clk_bps) begin
            state <= STOP;
          end
        end
`endif

        STOP: begin
          if (clk_bps) begin
            rx_data    <= shreg;
            frame_err  <= ~rx_sync;
            rx_valid   <= 1'b1;
            overrun    <= rx_valid & ~rx_ack;
`ifdef UART_RX_PARITY_EN
            parity_err <= ^{shreg, par_q};
`endif
            state      <= IDLE;
            bps_start  <= 1'b0;
            busy       <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          bps_start <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of flops in the rs232_rx synchronizer (legal values 2..3).
REQ-002 clk  input  1  system clock, 25 MHz.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rs232_rx  input  1  asynchronous serial line, idle high.
REQ-005 clk_bps  input  1  one-clk mid-bit sample strobe from the baud generator; present only while bps_start is high.
REQ-006 bps_start  output  1  high requests baud strobes; low holds the baud generator in reset.
REQ-007 rx_data  output  8  last received byte, LSB first on line.
REQ-008 rx_valid  output  1  byte available; held until rx_ack.
REQ-009 rx_ack  input  1  consumer accepts rx_data; clears rx_valid.
REQ-010 frame_err  output  1  stop bit sampled low for the byte in rx_data.
REQ-011 overrun  output  1  one-clk pulse: new byte completed while rx_valid was high and rx_ack low.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 rs232_rx SHALL pass through a SYNC_STAGES flop synchronizer, reset value 1, before any use.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY (PARITY_EN only), STOP.
REQ-015 IDLE: synchronized falling edge (prev 1, cur 0) -> START and bps_start=1 on the next clk; edges are ignored outside IDLE.
REQ-016 START on clk_bps: sample 1 -> false start, return to IDLE, bps_start=0, no output change; sample 0 -> DATA, bit counter=0.
REQ-017 DATA on each clk_bps: shift sample into bit[counter]; counter is 3 bits; after counter 7 -> PARITY if PARITY_EN, else STOP.
REQ-018 STOP on clk_bps: load rx_data from the shift register, frame_err = ~sample, set rx_valid, return to IDLE and drop bps_start, all on the clk after the strobe (latency 1 clk).
REQ-019 States SHALL advance only on clk_bps; no timeout exists between strobes.
REQ-020 rx_ack with rx_valid high SHALL clear rx_valid on the next clk; rx_ack with rx_valid low SHALL have no effect.
REQ-021 Completion and rx_ack in the same clk SHALL leave rx_valid=1 with new data and no overrun pulse.
REQ-022 Completion with rx_valid=1 and rx_ack=0 SHALL overwrite rx_data and frame_err and pulse overrun for one clk.
REQ-023 A falling edge in the same clk as returning to IDLE SHALL be ignored; detection restarts from IDLE.

Reset
REQ-024 Assertion of rst_n low SHALL immediately force: state IDLE, bps_start 0, rx_data 0x00, rx_valid 0, frame_err 0, overrun 0, busy 0, synchronizer all 1, counter 0.
REQ-025 Reset mid-frame SHALL abandon the frame with no rx_valid; reception resumes at the first falling edge after release.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: PARITY state samples one even-parity bit on clk_bps; output parity_err (1 bit, reset 0) is loaded with rx_valid, 1 when the XOR of the 8 data bits and the parity bit is 1.
REQ-027 Macro undefined: no PARITY state, no parity_err port; frame is 1 start, 8 data, 1 stop bit.

Verification
Bench baud model: first clk_bps 651 clks after bps_start rises, then every 1303 clks; held in reset while bps_start is low.
REQ-028 Send 0xA5 with valid stop -> rx_data=0xA5, rx_valid=1 one clk after the stop strobe, frame_err=0, bps_start=0, busy=0.
REQ-029 Low glitch of 100 clks on idle line -> START sample 1, return to IDLE, rx_valid stays 0, bps_start drops.
REQ-030 Send 0x3C with stop bit low -> rx_data=0x3C, frame_err=1, rx_valid=1.
REQ-031 Send 0x11 then 0x22 with no rx_ack -> rx_data=0x22, one-clk overrun pulse; repeat with rx_ack on the completion clk -> rx_valid=1, no overrun.
REQ-032 Assert rst_n low during data bit 4 of 0x55, release, then send 0x0F -> only 0x0F is reported.
REQ-033 With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> parity_err=1; send 0x07 with parity bit 1 -> parity_err=0.
